cache_axi_rd_arbiter: RTL
=========================

Name: cache_axi_rd_arbiter

Overview:
Shares the single AXI read-address/read-data channel pair between ICache refill and DCache refill/uncached-load requests. One transaction is outstanding at a time: AR issue, then R beats routed to the owner. DCache has priority. Reads are held while the write-back path is draining a line that matches the read address. Sits between both caches and the top-level AXI bridge; the write channels are outside this block.

Parameters:
LINE_WORDS, 4, words per cache line (16-byte line, 4-bit offset); arlen for line reads = LINE_WORDS-1
IC_ID, 4'd0, arid used for ICache transactions
DC_ID, 4'd1, arid used for DCache transactions

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active low
ic_rd_req  in  1  ICache line-read request; held until accepted
ic_rd_addr  in  32  ICache line address, offset bits must be zero
ic_rd_rdy  out  1  ICache request accepted this cycle
ic_ret_valid  out  1  ret_data holds an ICache beat
ic_ret_last  out  1  last ICache beat
dc_rd_req  in  1  DCache read request
dc_rd_type  in  1  0 = single uncached word, 1 = full line
dc_rd_addr  in  32  DCache read address
dc_rd_rdy  out  1  DCache request accepted this cycle
dc_ret_valid  out  1  ret_data holds a DCache beat
dc_ret_last  out  1  last DCache beat
ret_data  out  32  shared return data (= rdata)
wb_busy  in  1  write-back path has an unfinished write (until bvalid)
wb_line  in  28  line address [31:4] of that write
arid  out  4  IC_ID or DC_ID
araddr  out  32  latched request address
arlen  out  8  LINE_WORDS-1 for line, 0 for word
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  read data
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, owner=IC; arvalid, rready, *_rd_rdy, *_ret_valid, *_ret_last=0. Reset mid-burst abandons the transaction. The slave is reset together with this block.
- FSM states: IDLE, AR, DATA.
- IDLE: the candidate is dc if dc_rd_req, else ic if ic_rd_req. The candidate is blocked if wb_busy && wb_line==addr[31:4].
- IDLE, unblocked: winner's *_rd_rdy=1 combinationally, loser's=0. On that edge, latch owner, addr, len and go to AR. ic accepts only when dc_rd_req=0.
- AR: arvalid=1 with stable arid/araddr/arlen. On arvalid&&arready go to DATA. arvalid is never asserted in IDLE, so earliest arvalid is 1 cycle after accept.
- DATA: rready=1. Owner's ret_valid=rvalid, ret_last=rvalid&&rlast, ret_data=rdata, all combinational, 0-cycle latency. On rvalid&&rlast go to IDLE. A new accept is possible in the following cycle (min 1 idle cycle between transactions).
- Beats without rlast never change state. Non-owner ret_valid is always 0.
- Word read: arlen=0; the single beat carries rlast=1.
- Hazard: a blocked request keeps *_rd_rdy=0 until wb_busy drops or wb_line changes. A blocked dc does not let ic win the same cycle (strict priority, no bypass).
- Address/type sampled only at accept; later changes on req-side inputs are ignored until the next IDLE.

Decomposition:
- Shared package axi_defs: state encoding, IC_ID/DC_ID, LEN_LINE/LEN_WORD constants, line-address slice width 28.
- arsize=3'b010 and arburst=INCR are tied at top from the package constants.
- No sub-module; single FSM plus owner/address registers.

Test Plan:
- Reset: resetn=0 with ic_rd_req=dc_rd_req=1 -> arvalid=0, both rdy=0; release -> dc_rd_rdy=1 next cycle.
- Simultaneous: ic 0x1FC00000 line + dc 0x00001230 word same cycle -> dc_rd_rdy=1, arid=1, araddr=0x00001230, arlen=0. ic then served with arid=0, arlen=3.
- ICache line: arready delayed 3 cycles, rvalid gaps -> arvalid held stable. 4 ic_ret_valid pulses, data in order, ic_ret_last only on beat 4, dc_ret_valid stays 0.
- Hazard: wb_busy=1, wb_line=0x0000123, dc line read 0x00001230 -> dc_rd_rdy=0. wb_busy falls -> dc_rd_rdy=1 next cycle. Different line (0x00001240) accepted immediately.
- Mid-burst reset: assert resetn=0 after beat 2 -> next cycle state IDLE, rready=0, ret_valid=0.
- Back-to-back: dc held continuously for 3 word reads -> accept/AR/DATA loop, one IDLE cycle between each, arid=1 every time.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared definitions for the cache AXI read arbiter.
// Contents: FSM state encoding, owner encoding, default transaction IDs,
// burst-length constants, fixed AR attributes and a line-address helper.
package cache_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    localparam int          ID_W             = 4;
    localparam int          LINE_ADDR_W      = 28;
    localparam int          DEF_LINE_WORDS   = 4;
    localparam logic [3:0]  DEF_IC_ID        = 4'd0;
    localparam logic [3:0]  DEF_DC_ID        = 4'd1;
    localparam logic [7:0]  LEN_LINE         = 8'(DEF_LINE_WORDS - 1);
    localparam logic [7:0]  LEN_WORD         = 8'd0;

    // Every beat is a 32-bit word in an incrementing burst.
    localparam logic [2:0]  ARSIZE_WORD      = 3'b010;
    localparam logic [1:0]  ARBURST_INCR     = 2'b01;

    // 16-byte lines: the line address drops the 4 offset bits.
    function automatic logic [LINE_ADDR_W-1:0] line_of(input logic [31:0] addr);
        return addr[31:4];
    endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI read-address / read-data channel bundle.
// master : drives AR channel and rready (the arbiter)
// slave  : drives arready and the R channel (the AXI bridge / memory side)
interface cache_axi_rd_arbiter_if;
    import cache_axi_rd_arbiter_pkg::*;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rlast, rvalid
    );

endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Arbitrates the single AXI read channel between ICache refills and DCache
// refill / uncached loads. One transaction outstanding; DCache has strict
// priority; a request whose line is still being written back is held off.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   ic_rd_req/addr, ic_rd_rdy   ICache line-read request and accept strobe
//   ic_ret_valid/last           ICache return beat qualifiers
//   dc_rd_req/type/addr         DCache request (type 1 = line, 0 = word)
//   dc_rd_rdy                   DCache accept strobe
//   dc_ret_valid/last           DCache return beat qualifiers
//   ret_data                    shared return data
//   wb_busy, wb_line            outstanding write-back and its line address
//   axi                         AXI AR/R channels (master side)
//
// State | Meaning
// IDLE  | no transaction; arbitrate and accept one request
// AR    | arvalid high with latched id/addr/len, waiting for arready
// DATA  | rready high, beats routed to the owner until rlast
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [3:0] IC_ID      = DEF_IC_ID,
    parameter logic [3:0] DC_ID      = DEF_DC_ID
) (
    input  logic                   clk,
    input  logic                   resetn,

    input  logic                   ic_rd_req,
    input  logic [31:0]            ic_rd_addr,
    output logic                   ic_rd_rdy,
    output logic                   ic_ret_valid,
    output logic                   ic_ret_last,

    input  logic                   dc_rd_req,
    input  logic                   dc_rd_type,
    input  logic [31:0]            dc_rd_addr,
    output logic                   dc_rd_rdy,
    output logic                   dc_ret_valid,
    output logic                   dc_ret_last,

    output logic [31:0]            ret_data,

    input  logic                   wb_busy,
    input  logic [LINE_ADDR_W-1:0] wb_line,

    cache_axi_rd_arbiter_if.master axi
);

    localparam logic [7:0] LEN_LINE_P = 8'(LINE_WORDS - 1);

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;

    logic        cand_dc;
    logic        cand_valid;
    logic [31:0] cand_addr;
    logic [7:0]  cand_len;
    logic        blocked;
    logic        accept;

    // Candidate selection: DCache first. A blocked DCache request still
    // owns the slot, so ICache cannot slip past it.
    always_comb begin
        cand_dc    = dc_rd_req;
        cand_valid = dc_rd_req | ic_rd_req;
        cand_addr  = dc_rd_req ? dc_rd_addr : ic_rd_addr;
        cand_len   = LEN_LINE_P;
        if (dc_rd_req && !dc_rd_type) begin
            cand_len = LEN_WORD;
        end
        blocked    = wb_busy && (wb_line == line_of(cand_addr));
        // Gating with resetn keeps the accept strobes low while in reset.
        accept     = (state_q == ST_IDLE) && cand_valid && !blocked && resetn;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IC;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= cand_dc ? OWN_DC : OWN_IC;
                addr_q  <= cand_addr;
                len_q   <= cand_len;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)                       state_d = ST_AR;
            ST_AR:   if (axi.arready)                  state_d = ST_DATA;
            ST_DATA: if (axi.rvalid && axi.rlast)      state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dc_rd_rdy    = accept && cand_dc;
        ic_rd_rdy    = accept && !cand_dc;

        axi.arvalid  = (state_q == ST_AR);
        axi.arid     = (owner_q == OWN_DC) ? DC_ID : IC_ID;
        axi.araddr   = addr_q;
        axi.arlen    = len_q;
        axi.arsize   = ARSIZE_WORD;
        axi.arburst  = ARBURST_INCR;
        axi.rready   = (state_q == ST_DATA);

        ic_ret_valid = axi.rready && (owner_q == OWN_IC) && axi.rvalid;
        dc_ret_valid = axi.rready && (owner_q == OWN_DC) && axi.rvalid;
        ic_ret_last  = ic_ret_valid && axi.rlast;
        dc_ret_last  = dc_ret_valid && axi.rlast;
        ret_data     = axi.rdata;
    end

endmodule
